dff: RTL and testbench
======================

DFF -- requirements
Module: dff

Interface
REQ-001 Parameter SYNC_STAGES, default 1, range 1..4: number of rising-edge register stages between vco and DFF_1.
REQ-002 Parameter RESET_VALUE, default 1'b0: value loaded into every stage and DFF_1 while reset is asserted.
REQ-003 Port clk, input, 1: single sampling clock; all state updates on its rising edge only.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-high (asserted when 1) despite the name.
REQ-005 Port vco, input, 1: asynchronous VCO phase signal to be sampled.
REQ-006 Port DFF_1, output, 1: registered sample of vco after SYNC_STAGES clock edges.
REQ-007 The module SHALL have exactly one clock domain (clk) and no other ports.

Function
REQ-008 The module SHALL implement a shift chain s[0..SYNC_STAGES-1]; on each rising clk edge with reset deasserted: s[0] <= vco, s[k] <= s[k-1].
REQ-009 DFF_1 SHALL be driven directly from s[SYNC_STAGES-1], a flop output with no combinational path from vco.
REQ-010 Latency: a vco level stable across a rising clk edge SHALL appear on DFF_1 exactly SYNC_STAGES rising edges later (default: 1 edge).
REQ-011 DFF_1 SHALL change only on rising clk edges or on reset assertion, never on a vco transition alone.
REQ-012 vco pulses shorter than one clk period that contain no rising clk edge SHALL NOT appear on DFF_1.
REQ-013 vco changing at the same instant as a rising clk edge: the stage-0 value SHALL be either old or new vco, with later stages holding stable values; no X SHALL propagate in simulation when vco is 0/1.
REQ-014 With vco held constant for N >= SYNC_STAGES edges, DFF_1 SHALL equal vco and stay constant.
REQ-015 Illegal SYNC_STAGES (<1 or >4) SHALL be rejected at elaboration with an error.

Reset
REQ-016 While rst_n = 1, all stages and DFF_1 SHALL equal RESET_VALUE immediately (asynchronous), independent of clk.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight samples; no pre-reset vco value SHALL appear on DFF_1 after release.
REQ-018 After rst_n falls to 0, the first rising clk edge SHALL capture vco into s[0]; DFF_1 SHALL leave RESET_VALUE no earlier than SYNC_STAGES edges after release.
REQ-019 Reset asserted and released between two clk edges SHALL still leave all stages at RESET_VALUE.

Verification
REQ-020 Reset: clk period 2 ns, vco = 1, rst_n = 1 for 10 ns -> DFF_1 = 0 throughout, including between clk edges.
REQ-021 Tracking, SYNC_STAGES = 1: rst_n = 0, vco toggles every 10 ns for 20 periods -> DFF_1 follows vco delayed to the next rising clk edge, 20 high pulses of 10 ns each.
REQ-022 Latency, SYNC_STAGES = 3: vco 0->1 just after edge k -> DFF_1 rises at edge k+3, not earlier.
REQ-023 Glitch: 0.5 ns vco pulse placed between two rising edges -> DFF_1 stays 0.
REQ-024 Mid-run reset: rst_n pulsed to 1 for 0.3 ns between edges while vco = 1 and DFF_1 = 1 -> DFF_1 = 0 immediately, returns to 1 at the first edge after release (SYNC_STAGES = 1).
REQ-025 RESET_VALUE = 1: assert reset with vco = 0 -> DFF_1 = 1; release -> DFF_1 = 0 after SYNC_STAGES edges.

Source files
------------

// File: rtl/dff.sv
// VCO phase sampler: shifts the asynchronous vco level through SYNC_STAGES
// rising-edge flops in the clk domain and drives DFF_1 from the last one.
module dff #(
    parameter int   SYNC_STAGES = 1,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vco,
    output logic DFF_1
);

    if ((SYNC_STAGES < 1) || (SYNC_STAGES > 4)) begin : g_bad_stages
        $error("dff: SYNC_STAGES must be within 1..4");
    end

    logic [SYNC_STAGES-1:0] sync_r;

    // Sample chain; rst_n is active-high despite its name and clears every stage at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_r <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_r[0] <= vco;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign DFF_1 = sync_r[SYNC_STAGES-1];

endmodule

// File: tb/tb_dff.sv
// Checks dff in three configurations against an edge-history model of vco:
// output = vco seen N edges ago, or the reset value until N edges have elapsed.
`timescale 1ns/100ps
module tb_dff;

    logic clk = 1'b0;
    logic rst_n;
    logic vco;
    logic out1, out3, outr;

    int total = 0;
    int bad   = 0;

    // Model state: vco samples at each rising edge since the last reset, newest first.
    logic hist[$];
    int   cnt = 0;

    always #1 clk = ~clk;

    dff #(.SYNC_STAGES(1), .RESET_VALUE(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .vco(vco), .DFF_1(out1));
    dff #(.SYNC_STAGES(3), .RESET_VALUE(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .vco(vco), .DFF_1(out3));
    dff #(.SYNC_STAGES(2), .RESET_VALUE(1'b1)) ur (.clk(clk), .rst_n(rst_n), .vco(vco), .DFF_1(outr));

    function automatic logic exp_out(int n, logic rv);
        if (cnt >= n) return hist[n-1];
        else          return rv;
    endfunction

    task automatic chk(string tag, logic got, logic expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, expv);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, "/s1"},   out1, exp_out(1, 1'b0));
        chk({tag, "/s3"},   out3, exp_out(3, 1'b0));
        chk({tag, "/s2rv"}, outr, exp_out(2, 1'b1));
    endtask

    task automatic model_reset();
        cnt = 0;
        hist.delete();
    endtask

    // Advance to the next rising edge, record what it captured, check 0.5 ns later.
    task automatic tick(string tag);
        @(posedge clk);
        if (!rst_n) begin
            hist.push_front(vco);
            cnt++;
            if (hist.size() > 8) void'(hist.pop_back());
        end
        #0.5;
        chk_model(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        vco   = 1'b1;
        model_reset();
        #0.2;
        chk_model("rst_t0");

        // Held reset with vco=1, checked at and between edges
        for (int i = 0; i < 5; i++) begin
            tick("rst_hold");
            #1.0;
            chk_model("rst_mid");
        end
        rst_n = 1'b0;

        // Tracking: vco toggles every 10 ns
        vco = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((i % 5) == 0) vco = ~vco;
            tick("track");
        end

        // Latency of the 3-stage instance
        vco = 1'b0;
        for (int i = 0; i < 4; i++) tick("lat_pre");
        vco = 1'b1;
        tick("lat1"); chk("lat_k1", out3, 1'b0);
        tick("lat2"); chk("lat_k2", out3, 1'b0);
        tick("lat3"); chk("lat_k3", out3, 1'b1);

        // Short glitch between edges must not be captured
        vco = 1'b0;
        for (int i = 0; i < 4; i++) tick("gl_pre");
        vco = 1'b1;
        #0.5;
        vco = 1'b0;
        #0.2;
        chk("glitch_mid", out1, 1'b0);
        tick("glitch_edge");
        chk("glitch_after", out1, 1'b0);

        // Reset pulse between edges while the output is high
        vco = 1'b1;
        for (int i = 0; i < 4; i++) tick("mr_pre");
        chk("mr_before", out1, 1'b1);
        rst_n = 1'b1;
        #0.1;
        model_reset();
        chk("mr_s1_now",   out1, 1'b0);
        chk("mr_s3_now",   out3, 1'b0);
        chk("mr_rv_now",   outr, 1'b1);
        #0.2;
        rst_n = 1'b0;
        tick("mr_post1");
        chk("mr_s1_back", out1, 1'b1);
        chk("mr_s3_held", out3, 1'b0);

        // RESET_VALUE = 1 instance
        vco = 1'b0;
        for (int i = 0; i < 4; i++) tick("rv_pre");
        chk("rv_low", outr, 1'b0);
        rst_n = 1'b1;
        #0.1;
        model_reset();
        chk("rv_rst", outr, 1'b1);
        tick("rv_hold");
        rst_n = 1'b0;
        tick("rv_rel1"); chk("rv_e1", outr, 1'b1);
        tick("rv_rel2"); chk("rv_e2", outr, 1'b0);

        // Random levels, with occasional glitches and mid-period reset pulses
        for (int i = 0; i < 400; i++) begin
            vco = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                #0.3 vco = ~vco;
                #0.4 vco = ~vco;
            end else if ($urandom_range(0, 29) == 0) begin
                #0.2 rst_n = 1'b1;
                #0.1;
                model_reset();
                chk_model("rnd_rst");
                #0.2 rst_n = 1'b0;
            end else begin
                #0.1;
                chk_model("rnd_mid");
            end
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
